// File: rtl/ysyx_lsu_mem_responder_pkg.sv
// Shared types and constants for the LSU memory responder.
// Used by ysyx_lsu_mem_responder and ysyx_lsu_mem_lfsr.
package ysyx_lsu_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_HOLD
    } resp_state_e;

    localparam logic [7:0]  STRB_B    = 8'h01;
    localparam logic [7:0]  STRB_H    = 8'h03;
    localparam logic [7:0]  STRB_W    = 8'h0f;
    localparam logic [31:0] DEF_BASE  = 32'h8000_0000;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam int          CNT_W     = 5;

    // Byte enables of a right-aligned store after moving it to its lane.
    function automatic logic [3:0] lane_mask(input logic [7:0] strb,
                                             input logic [1:0] off);
        logic [7:0] m;
        case (strb & STRB_W)
            STRB_B:  m = STRB_B;
            STRB_H:  m = STRB_H;
            default: m = strb & STRB_W;
        endcase
        return m[3:0] << off;
    endfunction

endpackage

// File: rtl/ysyx_lsu_mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) for response latency jitter.
// Instantiated only when YSYX_LSU_RESP_RAND_DELAY_EN is defined.
module ysyx_lsu_mem_lfsr
    import ysyx_lsu_mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    logic fb;

    assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], fb};
        end
    end

endmodule

// File: rtl/ysyx_lsu_mem_responder.sv
// LSU bus memory responder with programmable latency; random extra
// latency enabled by defining YSYX_LSU_RESP_RAND_DELAY_EN.
module ysyx_lsu_mem_responder
    import ysyx_lsu_mem_responder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEF_BASE),
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    input  logic [7:0]        rstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic              resp_err
);

    localparam int                IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(MEM_WORDS * 4);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lat;
    logic              store_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        lane_q;
    logic [31:0]       data_q;
    logic [7:0]        strb_q;
    logic [DATA_W-1:0] rdata_q;

    logic [31:0] mem [MEM_WORDS];

    logic              st_req, ld_req, accept;
    logic              resp_ld, resp_st;
    logic [ADDR_W-1:0] req_addr, req_off;
    logic [31:0]       rd_word, rd_shift, wd;
    logic [3:0]        be;
    logic              unused_ok;

    assign st_req   = awvalid & wvalid;
    assign ld_req   = arvalid;
    assign accept   = (state_q == S_IDLE) & (st_req | ld_req);
    assign req_addr = st_req ? awaddr : araddr;
    assign req_off  = req_addr - BASE;

`ifdef YSYX_LSU_RESP_RAND_DELAY_EN
    logic [7:0] lfsr;

    ysyx_lsu_mem_lfsr u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .lfsr (lfsr)
    );

    assign lat       = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
    assign unused_ok = ^{rstrb, lfsr[7:2]};
`else
    assign lat       = CNT_W'(LATENCY);
    assign unused_ok = ^rstrb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = lat - CNT_W'(1);
                    state_d = (lat == CNT_W'(1)) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_ld  = (state_q == S_RESP) & ~store_q;
    assign resp_st  = (state_q == S_RESP) & store_q;
    assign rvalid   = resp_ld;
    assign wready   = resp_st;
    assign resp_err = (state_q == S_RESP) & err_q;

    assign rd_word  = mem[idx_q];
    assign rd_shift = err_q ? 32'd0 : (rd_word >> {lane_q, 3'b000});
    assign rdata    = resp_ld ? DATA_W'(rd_shift) : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            data_q  <= 32'd0;
            strb_q  <= 8'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                store_q <= st_req;
                err_q   <= ~(req_off < SPAN);
                idx_q   <= req_off[IDX_W+1:2];
                lane_q  <= req_addr[1:0];
                data_q  <= 32'(wdata);
                strb_q  <= wstrb;
            end
            if (resp_ld) rdata_q <= DATA_W'(rd_shift);
        end
    end

    // Lanes shifted past byte 3 fall off; the array has no reset.
    assign be = lane_mask(strb_q, lane_q);
    assign wd = data_q << {lane_q, 3'b000};

    always_ff @(posedge clk) begin
        if (resp_st && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_mem_responder.sv
// Randomized self-checking bench for ysyx_lsu_mem_responder.
// Byte-level memory model; response windows widen when the jitter macro is set.
module tb_ysyx_lsu_mem_responder;

    localparam int          LAT  = 2;
    localparam int          NW   = 1024;
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_LSU_RESP_RAND_DELAY_EN
    localparam int          JIT  = 3;
`else
    localparam int          JIT  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic        rvalid, wready, resp_err;
    logic [7:0]  rstrb = '0, wstrb = '0;

    ysyx_lsu_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(NW),
        .BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .rstrb(rstrb),
        .rdata(rdata), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem_m [NW*4];
    int          total = 0, bad = 0, cyc = 0, ready_edge = 0;
    int          exp_lo = 0, exp_hi = 0, got_cyc = 0;
    bit          exp_pend = 0, exp_st = 0, exp_err = 0, got = 0, tmo = 0;
    bit          last_st = 0, last_err = 0;
    logic [31:0] exp_rd = '0, last_rd = '0, hold_rd = '0;

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return d < NW * 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a);
        logic [31:0] r;
        int b, o;
        r = '0;
        if (!in_rng(a)) return r;
        b = int'((a - BASE) >> 2) * 4;
        o = int'(a[1:0]);
        for (int j = 0; j < 4; j++)
            if (o + j < 4) r[8*j +: 8] = mem_m[b + o + j];
        return r;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] s);
        int b, o;
        if (!in_rng(a)) return;
        b = int'((a - BASE) >> 2) * 4;
        o = int'(a[1:0]);
        for (int j = 0; j < 4; j++)
            if (s[j] && o + j < 4) mem_m[b + o + j] = d[8*j +: 8];
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Compare process: every cycle, against the expectation window.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            hold_rd = '0;
        end else begin
            if (!rvalid) begin
                total++;
                if (rdata !== hold_rd) begin
                    bad++;
                    $display("FAIL rdata_hold cyc=%0d: got %h want %h",
                             cyc, rdata, hold_rd);
                end
            end
            if (rvalid || wready) begin
                total++;
                if (!exp_pend || (rvalid && wready) || wready != exp_st ||
                    cyc < exp_lo || cyc > exp_hi) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d: rvalid=%b wready=%b want st=%b window %0d..%0d pend=%b",
                             cyc, rvalid, wready, exp_st, exp_lo, exp_hi, exp_pend);
                end else begin
                    total++;
                    if (resp_err !== exp_err) begin
                        bad++;
                        $display("FAIL resp_err cyc=%0d: got %b want %b",
                                 cyc, resp_err, exp_err);
                    end
                    if (rvalid) begin
                        total++;
                        if (rdata !== exp_rd) begin
                            bad++;
                            $display("FAIL rdata cyc=%0d: got %h want %h",
                                     cyc, rdata, exp_rd);
                        end
                        hold_rd = exp_rd;
                    end
                end
                last_st  = wready;
                last_err = resp_err;
                last_rd  = rdata;
                got      = 1;
                got_cyc  = cyc;
                exp_pend = 0;
            end else if (exp_pend && cyc > exp_hi) begin
                total++;
                bad++;
                $display("FAIL missing_pulse cyc=%0d: no response, window %0d..%0d",
                         cyc, exp_lo, exp_hi);
                exp_pend = 0;
                tmo      = 1;
            end
        end
    end

    task automatic scramble(input bit st);
        if (st) begin
            awaddr = $urandom;
            wdata  = $urandom;
            wstrb  = 8'($urandom);
        end else begin
            araddr = $urandom;
            rstrb  = 8'($urandom);
        end
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [7:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [7:0] s);
        araddr = a; rstrb = s; arvalid = 1;
    endtask

    // Called at a negedge with the request already driven.
    task automatic serve(input bit st, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] s);
        int acc, n;
        acc = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
        exp_st  = st;
        exp_err = !in_rng(a);
        if (st) m_store(a, d, s);
        else exp_rd = m_load(a);
        exp_lo = acc + LAT - 1;
        exp_hi = exp_lo + JIT;
        got = 0; tmo = 0; exp_pend = 1; n = 0;
        while (!got && !tmo && n < 64) begin
            @(negedge clk);
            n++;
            if (!got && cyc >= acc) scramble(st);
        end
        if (!got && !tmo) begin
            total++;
            bad++;
            $display("FAIL wait_budget: no response after %0d cycles", n);
            exp_pend = 0;
        end
        ready_edge = got ? got_cyc + 3 : cyc + 3;
        if (st) begin
            awvalid = 0; wvalid = 0;
        end else begin
            arvalid = 0;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] s);
        drive_store(a, d, s);
        serve(1, a, d, s);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [7:0] s);
        drive_load(a, s);
        serve(0, a, 32'd0, s);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 80) return BASE + $urandom_range(0, 63);
        if (r < 88) return BASE + 4 * (NW - 1) + $urandom_range(0, 3);
        case ($urandom_range(0, 3))
            0:       return 32'h0000_1000;
            1:       return BASE + NW * 4 + $urandom_range(0, 7);
            2:       return BASE - 1;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    function automatic logic [7:0] pick_strb();
        case ($urandom_range(0, 2))
            0:       return 8'h01;
            1:       return 8'h03;
            default: return 8'h0f;
        endcase
    endfunction

    initial begin
        int acc;
        logic [31:0] a, d, la;
        logic [7:0] s;
        for (int i = 0; i < NW * 4; i++) mem_m[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_wready", 32'(wready), 32'h0);
        chk("reset_resp_err", 32'(resp_err), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst_n = 1;
        ready_edge = cyc + 1;

        for (int w = 0; w < 16; w++) do_store(BASE + 4 * w, $urandom, 8'h0f);
        do_store(BASE + 4 * (NW - 1), $urandom, 8'h0f);

        do_store(BASE + 32'h10, 32'hDEAD_BEEF, 8'h0f);
        chk("st_word_wready", 32'(last_st), 32'h1);
        do_load(BASE + 32'h10, 8'h0f);
        chk("ld_word_data", last_rd, 32'hDEAD_BEEF);
        chk("ld_word_err", 32'(last_err), 32'h0);
        do_store(BASE + 32'h13, 32'h0000_005A, 8'h01);
        do_load(BASE + 32'h10, 8'h0f);
        chk("ld_merged", last_rd, 32'h5AAD_BEEF);
        do_load(BASE + 32'h13, 8'h01);
        chk("ld_byte", last_rd, 32'h0000_005A);

        drive_store(BASE + 32'h14, 32'h1234_5678, 8'h0f);
        drive_load(BASE + 32'h14, 8'h0f);
        serve(1, BASE + 32'h14, 32'h1234_5678, 8'h0f);
        chk("dual_store_first", 32'(last_st), 32'h1);
        serve(0, BASE + 32'h14, 32'd0, 8'h0f);
        chk("dual_load_after", last_rd, 32'h1234_5678);

        do_load(32'h0000_1000, 8'h0f);
        chk("oor_ld_data", last_rd, 32'h0);
        chk("oor_ld_err", 32'(last_err), 32'h1);
        do_store(BASE + NW * 4, 32'hFFFF_FFFF, 8'h0f);
        chk("oor_st_err", 32'(last_err), 32'h1);
        do_load(BASE, 8'h0f);
        do_load(BASE + 4 * (NW - 1), 8'h0f);

        drive_store(BASE + 32'h10, 32'h0BAD_0BAD, 8'h0f);
        acc = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
        while (cyc < acc) @(negedge clk);
        exp_pend = 0;
        rst_n = 0;
        #1;
        chk("midrst_wready", 32'(wready), 32'h0);
        chk("midrst_rvalid", 32'(rvalid), 32'h0);
        chk("midrst_resp_err", 32'(resp_err), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        awvalid = 0; wvalid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        ready_edge = cyc + 1;
        repeat (LAT + 4) @(negedge clk);
        do_load(BASE + 32'h10, 8'h0f);
        chk("midrst_no_write", last_rd, 32'h5AAD_BEEF);

        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = pick_addr();
            d = $urandom;
            s = pick_strb();
            case ($urandom_range(0, 9))
                0, 1, 2, 3:       do_load(a, s);
                4, 5, 6, 7, 8:    do_store(a, d, s);
                default: begin
                    la = pick_addr();
                    drive_store(a, d, s);
                    drive_load(la, s);
                    serve(1, a, d, s);
                    serve(0, la, 32'd0, s);
                end
            endcase
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
